mips_dmem_mmio_responder: RTL and testbench

- Responder at the data-memory end of the pipelined MIPS core's load/store interface.
- Inputs: the core's memWrite strobe, aluout address and writedata. Output: readdata, returned in the same cycle.
- Contains a word-addressed data RAM and a small MMIO block: free-running cycle counter, GPIO output register, byte TX FIFO with valid/ready drain, and sticky error/status register.

---
 rtl/mips_dmem_mmio_responder.sv | 135 +++++++++++++
 tb/tb_mips_dmem_mmio_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_mmio_responder.sv
// Data-memory responder for the pipelined MIPS core: word RAM plus a small MMIO block
// (free-running cycle counter, GPIO register, byte TX FIFO, sticky error status).
module mips_dmem_mmio_responder #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] gpio_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        err_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [FW:0] FIFO_FULL = (FW + 1)'(FIFO_DEPTH);

    logic [31:0]   ram [DEPTH];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] head;
    logic [FW-1:0] tail;
    logic [FW:0]   count;
    logic [31:0]   cycle_cnt;
    logic [31:0]   gpio_reg;
    logic          overflow_flag;
    logic          misaligned_flag;
    logic          unmapped_flag;

    logic          aligned;
    logic          in_ram;
    logic          in_mmio;
    logic [1:0]    reg_sel;
    logic          wr_ok;
    logic          wr_ram;
    logic          wr_gpio;
    logic          wr_tx;
    logic          wr_status;
    logic          set_misaligned;
    logic          set_unmapped;
    logic          set_overflow;
    logic          fifo_full;
    logic          pop;
    logic          accept;
    logic [31:0]   status_word;

    // The MMIO window is 16 bytes, so the top 28 address bits select it and bits [3:2] pick a register.
    assign aligned        = (aluout[1:0] == 2'b00);
    assign in_ram         = (aluout < RAM_BYTES);
    assign in_mmio        = (aluout[31:4] == MMIO_BASE[31:4]);
    assign reg_sel        = aluout[3:2];

    assign wr_ok          = memWrite && aligned;
    assign wr_ram         = wr_ok && in_ram;
    assign wr_gpio        = wr_ok && in_mmio && (reg_sel == 2'd1);
    assign wr_tx          = wr_ok && in_mmio && (reg_sel == 2'd2);
    assign wr_status      = wr_ok && in_mmio && (reg_sel == 2'd3);
    assign set_misaligned = memWrite && !aligned;
    assign set_unmapped   = wr_ok && !in_ram && !in_mmio;

    assign tx_valid       = (count != '0);
    assign tx_data        = fifo_mem[head];
    assign fifo_full      = (count == FIFO_FULL);
    assign pop            = tx_valid && tx_ready;
    assign accept         = wr_tx && (!fifo_full || pop);
    assign set_overflow   = wr_tx && fifo_full && !pop;

    assign gpio_out       = gpio_reg;
    assign err_irq        = overflow_flag || misaligned_flag || unmapped_flag;
    assign status_word    = {16'd0, 8'(count), 3'd0, unmapped_flag, misaligned_flag,
                             overflow_flag, fifo_full, !tx_valid};

    always_comb begin
        readdata = '0;
        if (in_ram) begin
            readdata = ram[aluout[AW+1:2]];
        end else if (in_mmio) begin
            case (reg_sel)
                2'd0:    readdata = cycle_cnt;
                2'd1:    readdata = gpio_reg;
                2'd2:    readdata = '0;
                default: readdata = status_word;
            endcase
        end
    end

    // Storage arrays carry no reset; only their pointers and counts do.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[aluout[AW+1:2]] <= writedata;
        end
        if (accept) begin
            fifo_mem[tail] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt       <= '0;
            gpio_reg        <= '0;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            overflow_flag   <= 1'b0;
            misaligned_flag <= 1'b0;
            unmapped_flag   <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_gpio) begin
                gpio_reg <= writedata;
            end
            if (pop) begin
                head <= head + FW'(1);
            end
            if (accept) begin
                tail <= tail + FW'(1);
            end
            if (accept && !pop) begin
                count <= count + (FW + 1)'(1);
            end else if (pop && !accept) begin
                count <= count - (FW + 1)'(1);
            end
            // A set in the same cycle as a write-1-to-clear takes priority.
            overflow_flag   <= set_overflow   || (overflow_flag   && !(wr_status && writedata[2]));
            misaligned_flag <= set_misaligned || (misaligned_flag && !(wr_status && writedata[3]));
            unmapped_flag   <= set_unmapped   || (unmapped_flag   && !(wr_status && writedata[4]));
        end
    end
endmodule

// File: tb/tb_mips_dmem_mmio_responder.sv
// Bench for mips_dmem_mmio_responder: directed scenarios then random traffic,
// all checked against a queue/array reference model of the memory map.
module tb_mips_dmem_mmio_responder;
    localparam int unsigned DEPTH      = 64;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] BASE       = 32'hFFFF_0000;
    localparam logic [31:0] RAM_BYTES  = 32'(DEPTH * 4);

    logic        clk;
    logic        reset;
    logic        memWrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] gpio_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        err_irq;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] mCycle;
    logic [31:0] mGpio;
    bit          mOvf;
    bit          mMis;
    bit          mUnm;
    logic [7:0]  mFifo [$];
    logic [31:0] mMem [DEPTH];
    bit          mValid [DEPTH];

    mips_dmem_mmio_responder #(
        .DEPTH(DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MMIO_BASE(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memWrite(memWrite),
        .aluout(aluout),
        .writedata(writedata),
        .readdata(readdata),
        .gpio_out(gpio_out),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .err_irq(err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void modelReset();
        mCycle = '0;
        mGpio  = '0;
        mOvf   = 1'b0;
        mMis   = 1'b0;
        mUnm   = 1'b0;
        mFifo.delete();
        for (int i = 0; i < int'(DEPTH); i++) mValid[i] = 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [31:0] w;
        int n;
        w = {a[31:2], 2'b00};
        n = mFifo.size();
        if (w < RAM_BYTES)         return mMem[int'(w >> 2)];
        if (w == BASE)             return mCycle;
        if (w == BASE + 32'd4)     return mGpio;
        if (w == BASE + 32'd8)     return 32'd0;
        if (w == BASE + 32'd12)
            return {16'd0, 8'(n), 3'd0, mUnm, mMis, mOvf, n == int'(FIFO_DEPTH), n == 0};
        return 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [31:0] w;
        w = {aluout[31:2], 2'b00};
        if (!(w < RAM_BYTES) || mValid[int'(w >> 2)])
            checkOutput({tag, "/readdata"}, readdata, modelRead(aluout));
        checkOutput({tag, "/gpio_out"}, gpio_out, mGpio);
        checkOutput({tag, "/tx_valid"}, {31'd0, tx_valid}, {31'd0, mFifo.size() != 0});
        if (mFifo.size() != 0)
            checkOutput({tag, "/tx_data"}, {24'd0, tx_data}, {24'd0, mFifo[0]});
        checkOutput({tag, "/err_irq"}, {31'd0, err_irq}, {31'd0, mOvf | mMis | mUnm});
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] data, input logic rdy);
        memWrite  = we;
        aluout    = addr;
        writedata = data;
        tx_ready  = rdy;
        #1;
    endtask

    // One rising edge; the model consumes the inputs that were held across it.
    task automatic tick();
        bit popNow;
        bit wasFull;
        @(posedge clk);
        popNow  = (mFifo.size() != 0) && tx_ready;
        wasFull = (mFifo.size() == int'(FIFO_DEPTH));
        if (popNow) void'(mFifo.pop_front());
        if (memWrite) begin
            if (aluout[1:0] != 2'b00) mMis = 1'b1;
            else if (aluout < RAM_BYTES) begin
                mMem[int'(aluout >> 2)]   = writedata;
                mValid[int'(aluout >> 2)] = 1'b1;
            end
            else if (aluout == BASE) begin end
            else if (aluout == BASE + 32'd4) mGpio = writedata;
            else if (aluout == BASE + 32'd8) begin
                if (!wasFull || popNow) mFifo.push_back(writedata[7:0]);
                else mOvf = 1'b1;
            end
            else if (aluout == BASE + 32'd12) begin
                if (writedata[2]) mOvf = 1'b0;
                if (writedata[3]) mMis = 1'b0;
                if (writedata[4]) mUnm = 1'b0;
            end
            else mUnm = 1'b1;
        end
        mCycle = mCycle + 32'd1;
        @(negedge clk);
    endtask

    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic rdy, input string tag);
        applyStimulus(we, addr, data, rdy);
        checkAll(tag);
        tick();
    endtask

    initial begin
        logic [7:0]  exp4 [4];
        logic [31:0] addr;
        int kind;

        reset = 1'b1; memWrite = 1'b0; aluout = BASE + 32'd12; writedata = '0; tx_ready = 1'b0;
        #1 reset = 1'b0;
        modelReset();
        #1;
        $display("[TB] reset state");
        checkOutput("rst/tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst/gpio_out", gpio_out, 32'd0);
        checkOutput("rst/err_irq", {31'd0, err_irq}, 32'd0);
        checkOutput("rst/status", readdata, 32'h0000_0001);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] cycle counter");
        for (int i = 0; i < 10; i++) tick();
        applyStimulus(1'b0, BASE, 32'd0, 1'b0);
        checkOutput("cycle/ten", readdata, 32'd10);
        checkAll("cycle/ten");
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        mCycle = 32'hFFFF_FFFE;
        applyStimulus(1'b0, BASE, 32'd0, 1'b0);
        checkOutput("cycle/preload", readdata, 32'hFFFF_FFFE);
        tick();
        tick();
        applyStimulus(1'b0, BASE, 32'd0, 1'b0);
        checkOutput("cycle/wrap", readdata, 32'd0);

        $display("[TB] RAM and misaligned store");
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, "ram/store");
        applyStimulus(1'b0, 32'h10, 32'd0, 1'b0);
        checkOutput("ram/load10", readdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h12, 32'd0, 1'b0);
        checkOutput("ram/load12", readdata, 32'hDEAD_BEEF);
        step(1'b1, 32'h12, 32'h1234_5678, 1'b0, "ram/misstore");
        applyStimulus(1'b0, 32'h10, 32'd0, 1'b0);
        checkOutput("ram/unchanged", readdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b0);
        checkOutput("ram/mis_bit", readdata & 32'h8, 32'h8);
        checkOutput("ram/mis_irq", {31'd0, err_irq}, 32'd1);
        step(1'b1, BASE + 32'd12, 32'h8, 1'b0, "ram/clr");
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b0);
        checkOutput("ram/mis_cleared", readdata & 32'h8, 32'h0);
        checkOutput("ram/irq_cleared", {31'd0, err_irq}, 32'd0);

        $display("[TB] FIFO fill, overflow, drain");
        for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'd8, 32'h41 + i, 1'b0, "fifo/fill");
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b0);
        checkOutput("fifo/full_status", readdata, 32'h0000_0402);
        step(1'b1, BASE + 32'd8, 32'h45, 1'b0, "fifo/overflow");
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b0);
        checkOutput("fifo/ovf_status", readdata, 32'h0000_0406);
        exp4 = '{8'h41, 8'h42, 8'h43, 8'h44};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b1);
            checkOutput("fifo/drain", {24'd0, tx_data}, {24'd0, exp4[i]});
            checkAll("fifo/drain");
            tick();
        end
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b1);
        checkOutput("fifo/empty", {31'd0, tx_valid}, 32'd0);

        $display("[TB] FIFO push while full and draining");
        step(1'b1, BASE + 32'd12, 32'h4, 1'b0, "fifo/clr_ovf");
        for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'd8, 32'h41 + i, 1'b0, "fifo/refill");
        applyStimulus(1'b1, BASE + 32'd8, 32'h55, 1'b1);
        checkOutput("fifo/head41", {24'd0, tx_data}, 32'h41);
        tick();
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b0);
        checkOutput("fifo/pushpop_status", readdata, 32'h0000_0402);
        exp4 = '{8'h42, 8'h43, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b1);
            checkOutput("fifo/order", {24'd0, tx_data}, {24'd0, exp4[i]});
            checkAll("fifo/order");
            tick();
        end

        $display("[TB] GPIO, unmapped, set-wins");
        step(1'b1, BASE + 32'd4, 32'h0000_00FF, 1'b0, "gpio/store");
        checkOutput("gpio/value", gpio_out, 32'h0000_00FF);
        step(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b0, "unm/store");
        applyStimulus(1'b0, 32'h0000_1000, 32'd0, 1'b0);
        checkOutput("unm/load", readdata, 32'd0);
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b0);
        checkOutput("unm/bit", readdata & 32'h10, 32'h10);
        step(1'b1, 32'h3, 32'd0, 1'b0, "mis/store");
        step(1'b1, BASE + 32'hD, 32'h8, 1'b0, "mis/status_write");
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b0);
        checkOutput("mis/set_wins", readdata & 32'h8, 32'h8);
        checkAll("mis/set_wins");

        $display("[TB] asynchronous reset mid-drain");
        for (int i = 0; i < 3; i++) step(1'b1, BASE + 32'd8, 32'h61 + i, 1'b0, "arst/fill");
        step(1'b1, BASE + 32'd4, 32'h5A, 1'b0, "arst/gpio");
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b1);
        checkOutput("arst/pre_valid", {31'd0, tx_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst/tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("arst/gpio_out", gpio_out, 32'd0);
        checkOutput("arst/err_irq", {31'd0, err_irq}, 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, BASE + 32'd12, 32'd0, 1'b0);
        checkOutput("arst/status", readdata, 32'h0000_0001);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 7));
            case (kind)
                0, 1:    addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
                2:       addr = BASE;
                3:       addr = BASE + 32'd4;
                4:       addr = BASE + 32'd8;
                5:       addr = BASE + 32'd12;
                6:       addr = 32'($urandom_range(0, DEPTH * 4 - 1));
                default: addr = $urandom;
            endcase
            step(1'($urandom_range(0, 1)), addr, $urandom, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
